// File: rtl/seq_divider_16b_pkg.sv
// Shared constants and types for the sequential divider.
//   DIV_WIDTH   : default operand / quotient / remainder width
//   CLA_GRP     : bit width of one carry-lookahead group
//   div_state_e : divider FSM states
package seq_divider_16b_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int CLA_GRP   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_16b_cla.sv
// Carry-lookahead adder built from 4-bit lookahead groups. Each group
// computes its internal carries in two-level form and exports a group
// generate/propagate pair that forms the inter-group carry.
// Ports:
//   a_i, b_i : addends (WIDTH bits)
//   cin_i    : carry in
//   sum_o    : a_i + b_i + cin_i (low WIDTH bits)
//   cout_o   : carry out of the top bit
module cla_16b
  import seq_divider_16b_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int NGRP = WIDTH / CLA_GRP;

  logic [NGRP:0] grp_c;

  assign grp_c[0] = cin_i;
  assign cout_o   = grp_c[NGRP];

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    logic [CLA_GRP-1:0] p;
    logic [CLA_GRP-1:0] g;
    logic [CLA_GRP-1:0] c;
    logic               grp_g;
    logic               grp_p;

    assign p = a_i[gi*CLA_GRP +: CLA_GRP] ^ b_i[gi*CLA_GRP +: CLA_GRP];
    assign g = a_i[gi*CLA_GRP +: CLA_GRP] & b_i[gi*CLA_GRP +: CLA_GRP];

    assign c[0] = grp_c[gi];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);

    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;

    assign grp_c[gi+1] = grp_g | (grp_p & c[0]);
    assign sum_o[gi*CLA_GRP +: CLA_GRP] = p ^ c;
  end

endmodule

// File: rtl/seq_divider_16b.sv
// Unsigned iterative restoring divider, one quotient bit per cycle.
// The trial subtraction R' - divisor runs through the CLA as
// R'[WIDTH-1:0] + ~divisor + 1; bit WIDTH of R' is folded into the
// borrow decision here.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (operands sampled at accept)
//   dividend, divisor     : unsigned operands
//   out_valid / out_ready : result handshake
//   quotient, remainder   : result, held stable while out_valid is high
//   div_by_zero           : result came from a zero divisor
module seq_divider_16b
  import seq_divider_16b_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH % CLA_GRP != 0) begin : g_width_check
    $error("seq_divider_16b: WIDTH must be a multiple of the CLA group size");
  end

  div_state_e       state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  // Only the low WIDTH bits of the partial remainder are stored: after a
  // completed step the remainder is always below the divisor, so bit WIDTH
  // is zero. The extra bit exists only in the shifted value r_shift.
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] dvsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dbz_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             no_borrow;

  cla_16b #(
    .WIDTH (WIDTH)
  ) u_cla (
    .a_i    (r_shift[WIDTH-1:0]),
    .b_i    (~dvsr_q),
    .cin_i  (1'b1),
    .sum_o  (diff),
    .cout_o (carry)
  );

  always_comb begin
    r_shift   = {r_q, q_q[WIDTH-1]};
    // A set top bit of R' already exceeds any WIDTH-bit divisor.
    no_borrow = carry | r_shift[WIDTH];
    r_d       = no_borrow ? diff : r_shift[WIDTH-1:0];
    q_d       = {q_q[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      r_q         <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvsr_q     <= divisor;
            cnt_q      <= CNT_W'(WIDTH - 1);
            dbz_q      <= (divisor == '0);
            in_ready_q <= 1'b0;
            if (divisor == '0) begin
              // Zero divisor: publish the all-ones / dividend result at once.
              q_q         <= '1;
              r_q         <= dividend;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              q_q     <= dividend;
              r_q     <= '0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          q_q <= q_d;
          r_q <= r_d;
          if (cnt_q == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;

endmodule
